// File: rtl/alarm_melody_seq.sv
// rtl/alarm_melody_seq.sv - alarm melody note sequencer feeding the PWM tone generator
// Optional pass limit: define ALARM_SEQ_REPEAT_LIMIT_EN to auto-mute after MAX_REPEATS passes.
module alarm_melody_seq #(
  parameter int TICK_DIV    = 100000,
  parameter int NOTE_MS     = 200,
  parameter int GAP_MS      = 20,
  parameter int MAX_REPEATS = 3
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       alarm_req,
  input  logic       silence,
  input  logic [1:0] pattern_sel,
  output logic [3:0] note,
  output logic       busy,
  output logic [2:0] step_idx,
  output logic       pass_done
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX  = (4 * NOTE_MS > GAP_MS) ? 4 * NOTE_MS : GAP_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, MUTED} state_t;

  state_t             state;
  logic [1:0]         pat;
  logic [PRESC_W-1:0] presc;
  logic [MS_W-1:0]    ms_cnt;

`ifdef ALARM_SEQ_REPEAT_LIMIT_EN
  localparam int PASS_W = $clog2(MAX_REPEATS + 1);
  logic [PASS_W-1:0] pass_cnt;
`endif

  // Each ROM word is {note[3:0], len[1:0]}.
  function automatic logic [5:0] rom(input logic [1:0] p, input logic [2:0] idx);
    logic [3:0] n;
    logic [1:0] l;
    n = 4'd0;
    l = 2'd0;
    case (p)
      2'd0: begin
        case (idx)
          3'd0: n = 4'd1;
          3'd1: n = 4'd3;
          3'd2: n = 4'd5;
          3'd3: n = 4'd8;
          3'd4: n = 4'd5;
          3'd5: n = 4'd3;
          3'd6: n = 4'd1;
          default: n = 4'd0;
        endcase
      end
      2'd1: begin
        n = idx[0] ? 4'd0 : 4'd13;
        l = 2'd1;
      end
      2'd2: n = idx[0] ? 4'd1 : 4'd15;
      default: begin
        case (idx)
          3'd0: n = 4'd8;
          3'd1: n = 4'd5;
          3'd2: n = 4'd3;
          3'd3: n = 4'd1;
          default: n = 4'd0;
        endcase
        l = idx[2] ? 2'd3 : 2'd1;
      end
    endcase
    return {n, l};
  endfunction

  logic [5:0] cur_word;
  logic [5:0] next_word;
  logic [5:0] first_word;
  logic       tick;
  logic       play_done;
  logic       gap_done;
  logic       step_end;
  logic       keep_going;
  int         play_ticks;

  always_comb begin
    cur_word   = rom(pat, step_idx);
    next_word  = rom(pat, step_idx + 3'd1);
    first_word = rom(pattern_sel, 3'd0);
    play_ticks = (int'(cur_word[1:0]) + 1) * NOTE_MS;
    tick       = (presc == PRESC_W'(TICK_DIV - 1));
    play_done  = (state == PLAY) && tick && (ms_cnt == MS_W'(play_ticks - 1));
    gap_done   = (state == GAP) && tick && (ms_cnt == MS_W'(GAP_MS - 1));
    step_end   = (GAP_MS == 0) ? play_done : gap_done;
`ifdef ALARM_SEQ_REPEAT_LIMIT_EN
    keep_going = alarm_req && ((int'(pass_cnt) + 1) < MAX_REPEATS);
`else
    keep_going = alarm_req;
`endif
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pat       <= 2'd0;
      presc     <= '0;
      ms_cnt    <= '0;
      note      <= 4'd0;
      busy      <= 1'b0;
      step_idx  <= 3'd0;
      pass_done <= 1'b0;
`ifdef ALARM_SEQ_REPEAT_LIMIT_EN
      pass_cnt  <= '0;
`endif
    end else begin
      pass_done <= 1'b0;
      if (tick) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + MS_W'(1);
      end else begin
        presc  <= presc + PRESC_W'(1);
      end

      case (state)
        IDLE: begin
          note     <= 4'd0;
          busy     <= 1'b0;
          step_idx <= 3'd0;
          presc    <= '0;
          ms_cnt   <= '0;
          if (alarm_req && silence) begin
            state <= MUTED;
          end else if (alarm_req) begin
            state <= PLAY;
            pat   <= pattern_sel;
            note  <= first_word[5:2];
            busy  <= 1'b1;
          end
        end

        PLAY, GAP: begin
          // Mute wins over any step advance or wrap in the same cycle.
          if (silence) begin
            state    <= MUTED;
            note     <= 4'd0;
            busy     <= 1'b0;
            step_idx <= 3'd0;
            presc    <= '0;
            ms_cnt   <= '0;
          end else if (play_done && (GAP_MS != 0)) begin
            state  <= GAP;
            note   <= 4'd0;
            presc  <= '0;
            ms_cnt <= '0;
          end else if (step_end) begin
            presc  <= '0;
            ms_cnt <= '0;
            if (step_idx != 3'd7) begin
              state    <= PLAY;
              step_idx <= step_idx + 3'd1;
              note     <= next_word[5:2];
            end else begin
              pass_done <= 1'b1;
              step_idx  <= 3'd0;
`ifdef ALARM_SEQ_REPEAT_LIMIT_EN
              pass_cnt  <= pass_cnt + PASS_W'(1);
`endif
              if (keep_going) begin
                state <= PLAY;
                pat   <= pattern_sel;
                note  <= first_word[5:2];
              end else if (alarm_req) begin
                state <= MUTED;
                note  <= 4'd0;
                busy  <= 1'b0;
              end else begin
                state <= IDLE;
                note  <= 4'd0;
                busy  <= 1'b0;
`ifdef ALARM_SEQ_REPEAT_LIMIT_EN
                pass_cnt <= '0;
`endif
              end
            end
          end
        end

        default: begin
          note     <= 4'd0;
          busy     <= 1'b0;
          step_idx <= 3'd0;
          presc    <= '0;
          ms_cnt   <= '0;
          if (!alarm_req) begin
            state <= IDLE;
`ifdef ALARM_SEQ_REPEAT_LIMIT_EN
            pass_cnt <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule
